// File: rtl/solver_run_ctrl_if.sv
// Avalon-MM slave register bus for the solver run controller.
// The host or interconnect side uses the master modport; the controller uses the slave modport.
interface solver_run_ctrl_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/solver_run_ctrl.sv
// Sequencer for one solver run: launches the datapath, waits for completion, abort or timeout,
// and then reports sticky status and an interrupt to software through four Avalon-MM registers.
module solver_run_ctrl #(
    parameter logic [31:0] DEFAULT_TIMEOUT = 32'd0
) (
    input  logic                     clk,
    input  logic                     reset_n,
    solver_run_ctrl_if.slave         bus,
    input  logic                     solver_done_in,
    output logic                     solver_start,
    output logic                     solver_abort,
    output logic                     done_out,
    output logic                     irq
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        RUN    = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] limit_q, limit_d;
    logic        irq_en_q, irq_en_d;
    logic        done_q, done_d;
    logic        timeout_q, timeout_d;
    logic        aborted_q, aborted_d;
    logic        abort_pulse_q, abort_pulse_d;

    logic        bus_wr;
    logic        ctrl_wr;
    logic        status_wr;
    logic        limit_wr;
    logic        start_req;
    logic        abort_req;
    logic        limit_hit;
    logic        busy;
    logic [31:0] cnt_inc;

    assign bus_wr    = bus.chipselect && !bus.write_n;
    assign ctrl_wr   = bus_wr && (bus.address == 2'd0);
    assign status_wr = bus_wr && (bus.address == 2'd1);
    assign limit_wr  = bus_wr && (bus.address == 2'd2);
    assign start_req = ctrl_wr && bus.writedata[0];
    assign abort_req = ctrl_wr && bus.writedata[1];
    assign limit_hit = (limit_q != 32'd0) && (cnt_q >= limit_q);
    assign busy      = (state_q != IDLE);
    assign cnt_inc   = (cnt_q == 32'hFFFF_FFFF) ? cnt_q : cnt_q + 32'd1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Exit priority in RUN: datapath completion beats an abort write, which beats the timeout.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start_req) state_d = LAUNCH;
            end
            LAUNCH: begin
                state_d = abort_req ? IDLE : RUN;
            end
            RUN: begin
                if (solver_done_in || abort_req || limit_hit) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Flag sets come after the W1C clears so a same-cycle set wins.
    always_comb begin
        cnt_d         = cnt_q;
        limit_d       = limit_q;
        irq_en_d      = irq_en_q;
        done_d        = done_q;
        timeout_d     = timeout_q;
        aborted_d     = aborted_q;
        abort_pulse_d = 1'b0;

        if (ctrl_wr) irq_en_d = bus.writedata[2];
        if (limit_wr && !busy) limit_d = bus.writedata;
        if (status_wr) begin
            if (bus.writedata[1]) done_d    = 1'b0;
            if (bus.writedata[2]) timeout_d = 1'b0;
            if (bus.writedata[3]) aborted_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (start_req) begin
                    cnt_d     = 32'd0;
                    done_d    = 1'b0;
                    timeout_d = 1'b0;
                    aborted_d = 1'b0;
                end
            end
            LAUNCH: begin
                if (abort_req) begin
                    aborted_d     = 1'b1;
                    abort_pulse_d = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            RUN: begin
                if (solver_done_in) begin
                    done_d = 1'b1;
                end else if (abort_req) begin
                    aborted_d     = 1'b1;
                    abort_pulse_d = 1'b1;
                end else if (limit_hit) begin
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q         <= 32'd0;
            limit_q       <= DEFAULT_TIMEOUT;
            irq_en_q      <= 1'b0;
            done_q        <= 1'b0;
            timeout_q     <= 1'b0;
            aborted_q     <= 1'b0;
            abort_pulse_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            limit_q       <= limit_d;
            irq_en_q      <= irq_en_d;
            done_q        <= done_d;
            timeout_q     <= timeout_d;
            aborted_q     <= aborted_d;
            abort_pulse_q <= abort_pulse_d;
        end
    end

    always_comb begin
        solver_start = (state_q == LAUNCH);
        solver_abort = abort_pulse_q;
        done_out     = done_q;
        irq          = irq_en_q && (done_q || timeout_q || aborted_q);
        case (bus.address)
            2'd0:    bus.readdata = {29'b0, irq_en_q, 2'b0};
            2'd1:    bus.readdata = {28'b0, aborted_q, timeout_q, done_q, busy};
            2'd2:    bus.readdata = limit_q;
            default: bus.readdata = cnt_q;
        endcase
    end

endmodule
